// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage.
// Optional perf counters in fetch_unit are enabled by FETCH_PERF_EN.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    DISCARD,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_REG  = 2'b01;
  localparam logic [1:0] PCSEL_JUMP = 2'b10;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: push/pop/flush FIFO with a combinational head.
module fetch_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = pop & (cnt_q != '0) & ~flush;
    do_push = push & ~flush & ((cnt_q != FULL) | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, redirect/flush and halt.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  output logic       iREN,
  output word_t      iaddr,
  input  word_t      iload,
  input  logic       ihit,
  output word_t      instr,
  output word_t      instr_pc,
  output word_t      instr_npc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic [1:0] pc_sel,
  input  logic       brEn,
  input  logic       halt,
  input  word_t      br_imm,
  input  word_t      rs_val,
`ifdef FETCH_PERF_EN
  output word_t      perf_fetched,
  output word_t      perf_stall,
`endif
  output logic       halted
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  fetch_state_t  state_q, state_d;
  word_t         pc_q, pc_d;
  word_t         iaddr_q, iaddr_d;
  logic          en_q, en_d;
  logic          halt_pend_q, halt_pend_d;
  logic          halted_q, halted_d;
  logic          push, flush, pop;
  logic          redir, stop, busy;
  logic [1:0]    sel;
  word_t         target;
  fetch_entry_t  wdata;
  fetch_entry_t  head;
  logic [CW-1:0] count;

  assign wdata = '{instr: iload, pc: iaddr_q};

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk  (CLK),
    .rst_n(nRST),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(wdata),
    .head (head),
    .count(count)
  );

  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_npc   = head.pc + 32'd4;
  assign instr_valid = (count != '0);
  assign iaddr       = iaddr_q;
  assign halted      = halted_q;
  assign en_d        = 1'b1;

  assign pop   = instr_valid & instr_ready;
  assign sel   = (pc_sel == 2'b11) ? PCSEL_SEQ : pc_sel;
  assign redir = pop & ((sel != PCSEL_SEQ) | brEn);
  assign stop  = pop & halt;
  assign busy  = iREN & ~ihit;

  // en_q holds iREN low for the first cycle out of reset
  always_comb begin
    iREN = 1'b0;
    unique case (state_q)
      RUN:     iREN = en_q & (count < FULL);
      DISCARD: iREN = 1'b1;
      default: iREN = 1'b0;
    endcase
  end

  always_comb begin
    target = instr_npc + (br_imm << 2);
    unique case (1'b1)
      (sel == PCSEL_REG):  target = rs_val;
      (sel == PCSEL_JUMP): target = {instr_npc[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_pend_d = halt_pend_q;
    halted_d    = halted_q;
    push        = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (iREN & ihit) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      DISCARD: begin
        if (ihit) begin
          state_d     = halt_pend_q ? HALTED : RUN;
          halt_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (stop) begin
      push        = 1'b0;
      flush       = 1'b1;
      halted_d    = 1'b1;
      halt_pend_d = busy;
      state_d     = busy ? DISCARD : HALTED;
    end else if (redir) begin
      push    = 1'b0;
      flush   = 1'b1;
      pc_d    = target;
      state_d = busy ? DISCARD : RUN;
    end
    // an in-flight request keeps its address until ihit
    iaddr_d = (state_d == DISCARD) ? iaddr_q : pc_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      iaddr_q     <= PC_INIT;
      en_q        <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iaddr_q     <= iaddr_d;
      en_q        <= en_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
    end
  end

`ifdef FETCH_PERF_EN
  word_t fetched_q, fetched_d;
  word_t stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (state_q != HALTED) begin
      fetched_d = fetched_q + 32'(push);
      stall_d   = stall_q + 32'(busy);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (PC_INIT=0x40, 4-entry buffer).
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       iREN;
  word_t      iaddr;
  word_t      iload;
  logic       ihit = 1'b0;
  word_t      instr, instr_pc, instr_npc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [1:0] pc_sel = 2'b00;
  logic       brEn = 1'b0;
  logic       halt = 1'b0;
  word_t      br_imm = '0;
  word_t      rs_val = '0;
  logic       halted;
`ifdef FETCH_PERF_EN
  word_t      perf_fetched, perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt = 0;

  fetch_unit #(
    .PC_INIT  (32'h40),
    .BUF_DEPTH(4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iload       (iload),
    .ihit        (ihit),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_npc   (instr_npc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_sel      (pc_sel),
    .brEn        (brEn),
    .halt        (halt),
    .br_imm      (br_imm),
    .rs_val      (rs_val),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall),
`endif
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_word(word_t a);
    if (a == 32'h8000_0010) return 32'h0800_0040;
    return {8'hC0, a[23:0]};
  endfunction

  assign iload = mem_word(iaddr);

  // memory: wait_n idle cycles, then one ihit cycle
  always begin
    @(posedge CLK);
    #1;
    if (iREN) begin
      if (wcnt >= wait_n) begin
        ihit = 1'b1;
        wcnt = 0;
      end else begin
        ihit = 1'b0;
        wcnt++;
      end
    end else begin
      ihit = 1'b0;
      wcnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached", $time);
    $fatal(1);
  end

  task automatic do_reset();
    nRST = 1'b0;
    instr_ready = 1'b0;
    pc_sel = 2'b00;
    brEn = 1'b0;
    halt = 1'b0;
    wait_n = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    instr_ready = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iren got %b want 0", iREN); end
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL rst_iaddr got %h want 00000040", iaddr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", instr_pc); end
    checks++; if (instr_npc !== 32'h4) begin errors++; $display("FAIL rst_npc got %h want 4", instr_npc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    nRST = 1'b1;
  endtask

  task automatic test_seq();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL seq_iren got %b want 1", iREN); end
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL seq_iaddr0 got %h want 40", iaddr); end
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b want 1", instr_valid); end
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL seq_pc0 got %h want 40", instr_pc); end
    checks++; if (instr_npc !== 32'h44) begin errors++; $display("FAIL seq_npc0 got %h want 44", instr_npc); end
    checks++; if (instr !== 32'hC000_0040) begin errors++; $display("FAIL seq_instr0 got %h want c0000040", instr); end
    checks++; if (iaddr !== 32'h44) begin errors++; $display("FAIL seq_iaddr1 got %h want 44", iaddr); end
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL seq_pc1 got %h want 44", instr_pc); end
    checks++; if (iaddr !== 32'h48) begin errors++; $display("FAIL seq_iaddr2 got %h want 48", iaddr); end
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h48) begin errors++; $display("FAIL seq_pc2 got %h want 48", instr_pc); end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      checks++; if (instr_pc !== 32'h48) begin errors++; $display("FAIL bp_hold[%0d] got %h want 48", k, instr_pc); end
      checks++; if (iREN !== (k <= 2)) begin errors++; $display("FAIL bp_iren[%0d] got %b want %b", k, iREN, (k <= 2)); end
      if (k >= 3) begin
        checks++; if (iaddr !== 32'h58) begin errors++; $display("FAIL bp_iaddr[%0d] got %h want 58", k, iaddr); end
      end
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4C + 32'(4 * j)) begin
        errors++; $display("FAIL bp_drain[%0d] got %b/%h want 1/%h", j, instr_valid, instr_pc, 32'h4C + 32'(4 * j));
      end
    end
  endtask

  task automatic test_jump();
    pc_sel = 2'b01;
    rs_val = 32'h8000_0010;
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jr_flush got %b want 0", instr_valid); end
    checks++; if (iaddr !== 32'h8000_0010) begin errors++; $display("FAIL jr_iaddr got %h want 80000010", iaddr); end
    pc_sel = 2'b00;
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h8000_0010 || instr !== 32'h0800_0040) begin
      errors++; $display("FAIL j_head got %h/%h want 80000010/08000040", instr_pc, instr);
    end
    pc_sel = 2'b10;
    @(negedge CLK);
    checks++; if (iaddr !== 32'h8000_0100) begin errors++; $display("FAIL j_iaddr got %h want 80000100", iaddr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL j_flush got %b want 0", instr_valid); end
    pc_sel = 2'b00;
    @(negedge CLK);
    pc_sel = 2'b01;
    rs_val = 32'h200;
    @(negedge CLK);
    checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL jr2_iaddr got %h want 200", iaddr); end
    pc_sel = 2'b00;
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL wr_head got %h want 200", instr_pc); end
    pc_sel = 2'b01;
    rs_val = 32'hFFFF_FFFC;
    @(negedge CLK);
    checks++; if (iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_iaddr got %h want fffffffc", iaddr); end
    pc_sel = 2'b00;
    @(negedge CLK);
    checks++; if (instr_npc !== 32'h0) begin errors++; $display("FAIL wr_npc got %h want 0", instr_npc); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL wr_pcwrap got %h want 0", iaddr); end
    pc_sel = 2'b11;
    brEn = 1'b0;
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL sel11_noredir got %b/%h want 1/0", instr_valid, instr_pc);
    end
    pc_sel = 2'b00;
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL wr_seq got %h want 4", instr_pc); end
  endtask

  task automatic test_branch();
    pc_sel = 2'b01;
    rs_val = 32'h100;
    @(negedge CLK);
    pc_sel = 2'b00;
    instr_ready = 1'b0;
    @(negedge CLK);
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL br_head got %h want 100", instr_pc); end
    wait_n = 3;
    @(negedge CLK);
    checks++; if (iaddr !== 32'h108 || iREN !== 1'b1) begin
      errors++; $display("FAIL br_pending got %h/%b want 108/1", iaddr, iREN);
    end
    instr_ready = 1'b1;
    brEn = 1'b1;
    br_imm = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      brEn = 1'b0;
      if (k == 2) wait_n = 0;
      checks++; if (instr_valid !== 1'b0 || iaddr !== 32'h108 || iREN !== 1'b1) begin
        errors++; $display("FAIL br_discard[%0d] got %b/%h/%b want 0/108/1", k, instr_valid, iaddr, iREN);
      end
    end
    @(negedge CLK);
    checks++; if (iaddr !== 32'hFC || instr_valid !== 1'b0) begin
      errors++; $display("FAIL br_target got %h/%b want fc/0", iaddr, instr_valid);
    end
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFC) begin
      errors++; $display("FAIL br_first got %b/%h want 1/fc", instr_valid, instr_pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge CLK);
    wait_n = 5;
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || iREN !== 1'b1) begin
      errors++; $display("FAIL halt_setup got %b/%h/%b want 1/40/1", instr_valid, instr_pc, iREN);
    end
    instr_ready = 1'b1;
    halt = 1'b1;
    @(negedge CLK);
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_flush got %b want 0", instr_valid); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin
        errors++; $display("FAIL halt_pend[%0d] got %b/%h want 1/44", k, iREN, iaddr);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      checks++; if (iREN !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_stop[%0d] got %b/%b/%b want 0/1/0", k, iREN, halted, instr_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b1;
    repeat (3) @(negedge CLK);
    instr_ready = 1'b0;
    wait_n = 10;
    repeat (2) @(negedge CLK);
    checks++; if (iREN !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 32'h44) begin
      errors++; $display("FAIL mid_pre got %b/%b/%h want 1/1/44", iREN, instr_valid, instr_pc);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL mid_iren got %b want 0", iREN); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_npc !== 32'h4) begin
      errors++; $display("FAIL mid_head got %h/%h/%h want 0/0/4", instr, instr_pc, instr_npc);
    end
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL mid_iaddr got %h want 40", iaddr); end
    wait_n = 0;
    instr_ready = 1'b1;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
      errors++; $display("FAIL mid_restart got %b/%h want 1/40", iREN, iaddr);
    end
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      errors++; $display("FAIL mid_first got %b/%h want 1/40", instr_valid, instr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_jump();
    test_wrap();
    test_branch();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
